// File: rtl/acc_mmu_arbiter_pkg.sv
// rtl/acc_mmu_arbiter_pkg.sv - shared types for the LSU/accelerator MMU port arbiter
package acc_mmu_arbiter_pkg;

    localparam int unsigned DEFAULT_VLEN = 39;
    localparam int unsigned DEFAULT_PLEN = 56;

    // Translation exception as reported by the MMU
    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_LSU = 2'd1,
        ARB_BUSY_ACC = 2'd2,
        ARB_DRAIN    = 2'd3
    } acc_mmu_arb_state_e;

    typedef enum logic {
        OWNER_LSU = 1'b0,
        OWNER_ACC = 1'b1
    } acc_mmu_owner_e;

endpackage

// File: rtl/acc_mmu_arbiter.sv
// rtl/acc_mmu_arbiter.sv - shares one MMU translation port between the LSU and the accelerator
module acc_mmu_arbiter
    import acc_mmu_arbiter_pkg::*;
#(
    parameter int unsigned VLEN     = DEFAULT_VLEN,
    parameter int unsigned PLEN     = DEFAULT_PLEN,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                lsu_req_i,
    input  logic [VLEN-1:0]     lsu_vaddr_i,
    input  logic                lsu_is_store_i,
    output logic                lsu_valid_o,
    output logic [PLEN-1:0]     lsu_paddr_o,
    output exception_t          lsu_exception_o,
    input  logic                acc_mmu_req_i,
    input  logic [VLEN-1:0]     acc_vaddr_i,
    input  logic                acc_is_store_i,
    output logic                acc_mmu_valid_o,
    output logic [PLEN-1:0]     acc_paddr_o,
    output exception_t          acc_exception_o,
    output logic                mmu_req_o,
    output logic [VLEN-1:0]     mmu_vaddr_o,
    output logic                mmu_is_store_o,
    input  logic                mmu_valid_i,
    input  logic [PLEN-1:0]     mmu_paddr_i,
    input  exception_t          mmu_exception_i,
    output logic                busy_o,
    output logic [CntWidth-1:0] acc_wait_cnt_o
);

    acc_mmu_arb_state_e  state_q;
    acc_mmu_owner_e      last_grant_q;
    logic [VLEN-1:0]     vaddr_q;
    logic                is_store_q;
    logic [CntWidth-1:0] wait_cnt_q;

    logic arb_en;
    logic lsu_cand;
    logic acc_cand;
    logic grant_lsu;
    logic grant_acc;

    // Two-way round-robin; the owner completing this cycle may not win again immediately
    always_comb begin
        arb_en   = 1'b0;
        lsu_cand = 1'b0;
        acc_cand = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                arb_en   = 1'b1;
                lsu_cand = lsu_req_i;
                acc_cand = acc_mmu_req_i;
            end
            ARB_BUSY_LSU: begin
                arb_en   = mmu_valid_i;
                acc_cand = acc_mmu_req_i;
            end
            ARB_BUSY_ACC: begin
                arb_en   = mmu_valid_i;
                lsu_cand = lsu_req_i;
            end
            default: ;
        endcase
        grant_lsu = arb_en & lsu_cand & (~acc_cand | (last_grant_q == OWNER_ACC));
        grant_acc = arb_en & acc_cand & ~grant_lsu;
    end

    // Result routing: only the owner sees the MMU answer, a flushed LSU answer is dropped
    always_comb begin
        lsu_valid_o     = (state_q == ARB_BUSY_LSU) & mmu_valid_i & ~flush_i;
        acc_mmu_valid_o = (state_q == ARB_BUSY_ACC) & mmu_valid_i;
        lsu_paddr_o     = lsu_valid_o ? mmu_paddr_i : '0;
        lsu_exception_o = lsu_valid_o ? mmu_exception_i : '0;
        acc_paddr_o     = acc_mmu_valid_o ? mmu_paddr_i : '0;
        acc_exception_o = acc_mmu_valid_o ? mmu_exception_i : '0;
    end

    assign mmu_req_o      = (state_q != ARB_IDLE);
    assign busy_o         = (state_q != ARB_IDLE);
    assign mmu_vaddr_o    = vaddr_q;
    assign mmu_is_store_o = is_store_q;
    assign acc_wait_cnt_o = wait_cnt_q;

    // Ownership FSM with request latch; DRAIN keeps the MMU request up until the walk ends
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= OWNER_ACC;
            vaddr_q      <= '0;
            is_store_q   <= 1'b0;
        end else if (grant_lsu) begin
            state_q      <= ARB_BUSY_LSU;
            last_grant_q <= OWNER_LSU;
            vaddr_q      <= lsu_vaddr_i;
            is_store_q   <= lsu_is_store_i;
        end else if (grant_acc) begin
            state_q      <= ARB_BUSY_ACC;
            last_grant_q <= OWNER_ACC;
            vaddr_q      <= acc_vaddr_i;
            is_store_q   <= acc_is_store_i;
        end else if ((state_q == ARB_BUSY_LSU) && flush_i && !mmu_valid_i) begin
            state_q <= ARB_DRAIN;
        end else if ((state_q != ARB_IDLE) && mmu_valid_i) begin
            state_q <= ARB_IDLE;
        end
    end

    // Saturating count of cycles the accelerator request is not being served
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else if (acc_mmu_req_i && (state_q != ARB_BUSY_ACC) && (wait_cnt_q != '1)) begin
            wait_cnt_q <= wait_cnt_q + CntWidth'(1);
        end
    end

endmodule

// File: tb/tb_acc_mmu_arbiter.sv
// tb/tb_acc_mmu_arbiter.sv - self-checking bench for acc_mmu_arbiter
module tb_acc_mmu_arbiter;
    import acc_mmu_arbiter_pkg::*;

    localparam int VL = DEFAULT_VLEN;
    localparam int PL = DEFAULT_PLEN;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          lsu_req;
    logic [VL-1:0] lsu_vaddr;
    logic          lsu_store;
    logic          lsu_valid;
    logic [PL-1:0] lsu_paddr;
    exception_t    lsu_exc;
    logic          acc_req;
    logic [VL-1:0] acc_vaddr;
    logic          acc_store;
    logic          acc_valid;
    logic [PL-1:0] acc_paddr;
    exception_t    acc_exc;
    logic          mmu_req;
    logic [VL-1:0] mmu_vaddr;
    logic          mmu_store;
    logic          mmu_valid;
    logic [PL-1:0] mmu_paddr;
    exception_t    mmu_exc;
    logic          busy;
    logic [15:0]   wait_cnt;

    int checks = 0;
    int errors = 0;

    exception_t pf;

    acc_mmu_arbiter dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .lsu_req_i(lsu_req), .lsu_vaddr_i(lsu_vaddr), .lsu_is_store_i(lsu_store),
        .lsu_valid_o(lsu_valid), .lsu_paddr_o(lsu_paddr), .lsu_exception_o(lsu_exc),
        .acc_mmu_req_i(acc_req), .acc_vaddr_i(acc_vaddr), .acc_is_store_i(acc_store),
        .acc_mmu_valid_o(acc_valid), .acc_paddr_o(acc_paddr), .acc_exception_o(acc_exc),
        .mmu_req_o(mmu_req), .mmu_vaddr_o(mmu_vaddr), .mmu_is_store_o(mmu_store),
        .mmu_valid_i(mmu_valid), .mmu_paddr_i(mmu_paddr), .mmu_exception_i(mmu_exc),
        .busy_o(busy), .acc_wait_cnt_o(wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Reference model: who is being served, whether a cancelled walk is draining, fairness memory
    int            m_owner;   // 0 nobody, 1 LSU, 2 accelerator
    bit            m_drain;
    int            m_last;
    logic [VL-1:0] m_vaddr;
    bit            m_store;
    int            m_cnt;
    bit            m_known = 1'b0;

    always @(negedge clk) begin
        bit e_lsu_v;
        bit e_acc_v;
        bit lsu_c;
        bit acc_c;
        int win;
        if (m_known && !rst) begin
            e_lsu_v = (m_owner == 1) && mmu_valid && !flush;
            e_acc_v = (m_owner == 2) && mmu_valid;
            check("busy", busy, (m_owner != 0) || m_drain);
            check("mmu_req", mmu_req, (m_owner != 0) || m_drain);
            check("mmu_vaddr", mmu_vaddr, m_vaddr);
            check("mmu_is_store", mmu_store, m_store);
            check("lsu_valid", lsu_valid, e_lsu_v);
            check("acc_valid", acc_valid, e_acc_v);
            check("lsu_paddr", lsu_paddr, e_lsu_v ? mmu_paddr : '0);
            check("acc_paddr", acc_paddr, e_acc_v ? mmu_paddr : '0);
            check("lsu_exc", lsu_exc, e_lsu_v ? mmu_exc : '0);
            check("acc_exc", acc_exc, e_acc_v ? mmu_exc : '0);
            check("wait_cnt", wait_cnt, m_cnt[15:0]);
        end
        if (rst) begin
            m_owner = 0; m_drain = 0; m_last = 2; m_vaddr = '0; m_store = 0; m_cnt = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (acc_req && m_owner != 2 && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_drain) begin
                if (mmu_valid) m_drain = 0;
            end else if (m_owner == 1 && flush && !mmu_valid) begin
                m_drain = 1;
                m_owner = 0;
            end else if (m_owner == 0 || mmu_valid) begin
                lsu_c = lsu_req && m_owner != 1;
                acc_c = acc_req && m_owner != 2;
                if (lsu_c && acc_c) win = (m_last == 2) ? 1 : 2;
                else if (lsu_c)     win = 1;
                else if (acc_c)     win = 2;
                else                win = 0;
                m_owner = win;
                if (win == 1) begin m_last = 1; m_vaddr = lsu_vaddr; m_store = lsu_store; end
                if (win == 2) begin m_last = 2; m_vaddr = acc_vaddr; m_store = acc_store; end
            end
        end
    end

    initial begin
        rst = 1; flush = 0; lsu_req = 0; lsu_vaddr = '0; lsu_store = 0;
        acc_req = 0; acc_vaddr = '0; acc_store = 0; mmu_valid = 0; mmu_paddr = '0; mmu_exc = '0;
        pf.cause = 64'd15; pf.tval = 64'h3000; pf.valid = 1'b1;
        tick(); tick();
        rst = 0;
        at_neg();
        check("reset_busy", busy, 1'b0);
        check("reset_mmu_req", mmu_req, 1'b0);
        check("reset_cnt", wait_cnt, 16'd0);
        tick();

        // simultaneous pair after reset: LSU first, ACC on LSU completion
        lsu_req = 1; lsu_vaddr = 'h2000; acc_req = 1; acc_vaddr = 'h3000; acc_store = 1;
        tick();
        at_neg(); check("pair1_lsu_vaddr", mmu_vaddr, 'h2000); tick();
        mmu_valid = 1; mmu_paddr = 'h8000_2000;
        at_neg(); check("pair1_lsu_valid", lsu_valid, 1'b1); check("pair1_acc_quiet", acc_valid, 1'b0); tick();
        lsu_req = 0; mmu_valid = 0; mmu_paddr = '0;
        at_neg(); check("pair1_acc_vaddr", mmu_vaddr, 'h3000); check("pair1_acc_store", mmu_store, 1'b1); tick();
        // page fault routed to the accelerator only
        mmu_valid = 1; mmu_paddr = 'h9000_3000; mmu_exc = pf;
        at_neg();
        check("exc_acc_valid", acc_valid, 1'b1);
        check("exc_acc_exc", acc_exc, pf);
        check("exc_acc_paddr", acc_paddr, 'h9000_3000);
        check("exc_lsu_valid", lsu_valid, 1'b0);
        check("exc_lsu_exc", lsu_exc, '0);
        tick();
        acc_req = 0; acc_store = 0; mmu_valid = 0; mmu_paddr = '0; mmu_exc = '0;
        tick();

        // LSU-only, MMU answers three cycles after mmu_req_o
        lsu_req = 1; lsu_vaddr = 'h1000;
        tick();
        at_neg(); check("lsu_only_req", mmu_req, 1'b1); tick();
        tick(); tick();
        mmu_valid = 1; mmu_paddr = 'h8000_1000;
        at_neg();
        check("lsu_only_valid", lsu_valid, 1'b1);
        check("lsu_only_paddr", lsu_paddr, 'h8000_1000);
        check("lsu_only_acc_quiet", acc_valid, 1'b0);
        tick();
        lsu_req = 0; mmu_valid = 0; mmu_paddr = '0;
        tick();

        // second simultaneous pair: LSU went last, so ACC first
        lsu_req = 1; lsu_vaddr = 'h4000; acc_req = 1; acc_vaddr = 'h5000;
        tick();
        at_neg(); check("pair2_acc_vaddr", mmu_vaddr, 'h5000); tick();
        mmu_valid = 1; mmu_paddr = 'h8000_5000;
        tick();
        acc_req = 0; mmu_valid = 0;
        at_neg(); check("pair2_lsu_vaddr", mmu_vaddr, 'h4000); tick();
        mmu_valid = 1; mmu_paddr = 'h8000_4000;
        tick();
        lsu_req = 0; mmu_valid = 0; mmu_paddr = '0;
        tick();

        // flush two cycles after grant, walk ends five cycles later, ACC waits for the drain
        lsu_req = 1; lsu_vaddr = 'h6000;
        tick();
        acc_req = 1; acc_vaddr = 'h7000;
        tick();
        flush = 1; lsu_req = 0;
        tick();
        flush = 0;
        at_neg(); check("drain_req", mmu_req, 1'b1); check("drain_vaddr", mmu_vaddr, 'h6000); tick();
        tick(); tick(); tick();
        mmu_valid = 1; mmu_paddr = 'h8000_6000;
        at_neg(); check("drain_no_lsu", lsu_valid, 1'b0); check("drain_no_acc", acc_valid, 1'b0); tick();
        mmu_valid = 0; mmu_paddr = '0;
        at_neg(); check("drain_idle", busy, 1'b0); tick();
        at_neg(); check("drain_acc_vaddr", mmu_vaddr, 'h7000); tick();
        mmu_valid = 1; mmu_paddr = 'h8000_7000;
        at_neg(); check("drain_acc_valid", acc_valid, 1'b1); tick();
        acc_req = 0; mmu_valid = 0; mmu_paddr = '0;
        tick();

        // flush coincident with the result: dropped, no drain, ACC granted
        lsu_req = 1; lsu_vaddr = 'h8000;
        tick();
        acc_req = 1; acc_vaddr = 'h9000;
        tick();
        flush = 1; mmu_valid = 1; mmu_paddr = 'hdead_0000;
        at_neg(); check("flushv_lsu_valid", lsu_valid, 1'b0); check("flushv_lsu_paddr", lsu_paddr, '0); tick();
        flush = 0; mmu_valid = 0; lsu_req = 0; mmu_paddr = '0;
        at_neg(); check("flushv_acc_vaddr", mmu_vaddr, 'h9000); check("flushv_busy", busy, 1'b1); tick();
        mmu_valid = 1;
        tick();
        acc_req = 0; mmu_valid = 0;
        tick();

        // wait counter: ten cycles behind an LSU walk, then a long stall to saturation
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();
        lsu_req = 1; lsu_vaddr = 'hA000;
        tick();
        acc_req = 1; acc_vaddr = 'hB000;
        repeat (10) tick();
        at_neg(); check("cnt_ten", wait_cnt, 16'd10); tick();
        repeat (65540) tick();
        at_neg(); check("cnt_sat", wait_cnt, 16'hFFFF); tick();
        mmu_valid = 1;
        tick();
        lsu_req = 0; mmu_valid = 0;
        tick();
        mmu_valid = 1;
        tick();
        acc_req = 0; mmu_valid = 0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_mmu_arbiter.md
# acc_mmu_arbiter

Shares the core's single MMU translation port between the load/store unit and the accelerator (Ara) address-translation channel carried on the accelerator request/response interface. Each translation is granted to one requester, held until the MMU returns a result, and routed back only to that owner. Round-robin fairness applies on contention. An LSU flush cancels an in-flight LSU translation without corrupting MMU state. Sits in the CVA6 execute stage between `load_store_unit`/accelerator dispatcher and `mmu`.

## Interface
Parameters:
- `VLEN`, default `riscv::VLEN`: virtual address width.
- `PLEN`, default `riscv::PLEN`: physical address width.
- `CntWidth`, default 16: width of the accelerator wait-cycle counter.

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  cancel in-flight LSU translation.
- `lsu_req_i`  in  1  LSU translation request; held until `lsu_valid_o`.
- `lsu_vaddr_i`  in  VLEN  LSU virtual address.
- `lsu_is_store_i`  in  1  LSU access type.
- `lsu_valid_o`  out  1  LSU result valid, 1-cycle pulse.
- `lsu_paddr_o`  out  PLEN  LSU physical address.
- `lsu_exception_o`  out  `ariane_pkg::exception_t`  LSU translation exception.
- `acc_mmu_req_i`  in  1  accelerator request; held until `acc_mmu_valid_o`.
- `acc_vaddr_i`  in  VLEN  accelerator virtual address.
- `acc_is_store_i`  in  1  accelerator access type.
- `acc_mmu_valid_o`  out  1  accelerator result valid, 1-cycle pulse.
- `acc_paddr_o`  out  PLEN  accelerator physical address.
- `acc_exception_o`  out  `ariane_pkg::exception_t`  accelerator exception.
- `mmu_req_o`  out  1  request to MMU.
- `mmu_vaddr_o`  out  VLEN  latched vaddr of owner.
- `mmu_is_store_o`  out  1  latched access type.
- `mmu_valid_i`  in  1  MMU result valid.
- `mmu_paddr_i`  in  PLEN  MMU physical address.
- `mmu_exception_i`  in  `ariane_pkg::exception_t`  MMU exception.
- `busy_o`  out  1  state != IDLE.
- `acc_wait_cnt_o`  out  CntWidth  saturating count of cycles the accelerator request waits ungranted.

## Operation
- States: IDLE, BUSY_LSU, BUSY_ACC, DRAIN.
- Arbitration:
  - Evaluated in IDLE.
  - Also evaluated in BUSY_x on `mmu_valid_i`. The completing owner's request is excluded that cycle.
  - Single requester wins.
  - With both requesting, the winner is the one not granted last (`last_grant` register).
- Grant:
  - Registers `vaddr`/`is_store` of the winner into the latch.
  - Next state is BUSY_LSU or BUSY_ACC, and `last_grant` is updated.
- BUSY_x:
  - `mmu_req_o`=1 with the latched fields.
  - On `mmu_valid_i`, `mmu_paddr_i`/`mmu_exception_i` pass combinationally to the owner's outputs, with the owner's valid pulsed the same cycle.
  - Non-owner valid stays 0.
  - The next state follows re-arbitration, or is IDLE.
- Flush:
  - Affects only BUSY_LSU.
  - `flush_i` without `mmu_valid_i` → DRAIN.
  - `flush_i` with `mmu_valid_i` → `lsu_valid_o` suppressed; the normal next state applies.
  - `flush_i` in IDLE, BUSY_ACC or DRAIN is ignored.
- DRAIN:
  - `mmu_req_o` stays 1 with the latched fields until `mmu_valid_i`.
  - That result is discarded, with no valid to anyone; state → IDLE.
  - No grants are issued in DRAIN.
- `mmu_valid_i` in IDLE is ignored.
- `acc_wait_cnt_o` increments each cycle with `acc_mmu_req_i`=1 and state != BUSY_ACC, saturating at all-ones.

## Timing
- Reset values:
  - state IDLE; `last_grant`=ACC, so the LSU wins the first tie.
  - latches 0; counter 0.
  - all valid outputs 0; `mmu_req_o`=0; `busy_o`=0.
  - paddr/exception outputs 0 when not valid.
- Reset mid-translation aborts silently. The MMU is reset on the same `rst_i`.
- Latency:
  - Request seen in IDLE at cycle t → `mmu_req_o` at t+1.
  - Result returned in the same cycle as `mmu_valid_i`.
  - Minimum request-to-result is 1 cycle plus MMU latency.
- Back-to-back:
  - The other requester is granted on the completing cycle.
  - Its `mmu_req_o` is asserted on the next cycle, with no IDLE bubble.
- `mmu_req_o` is registered-state driven, with no combinational path from `*_req_i`.

## Structure
- `acc_pkg` gains `acc_mmu_arb_state_e` (IDLE, BUSY_LSU, BUSY_ACC, DRAIN) and `acc_mmu_owner_e` (LSU, ACC).
- No sub-module: the two-way round-robin is inline.
- Saturating counter is inline.

## Test plan
- LSU-only request:
  - Stimulus: `lsu_req_i`=1, vaddr 0x1000; MMU returns paddr 0x8000_1000 three cycles after `mmu_req_o`.
  - Required: `lsu_valid_o` pulses once with 0x8000_1000; `acc_mmu_valid_o` stays 0.
- Simultaneous requests after reset:
  - Required: LSU granted first, ACC granted on the LSU completion cycle with `mmu_vaddr_o`=acc addr the next cycle.
  - A second simultaneous pair goes to ACC first.
- Flush during LSU walk:
  - Stimulus: `flush_i` 2 cycles after grant; MMU valid 5 cycles later.
  - Required: DRAIN entered; `mmu_req_o` held; no `lsu_valid_o`.
  - A pending ACC request is granted only after the drain completes.
- Flush coincident with `mmu_valid_i` in BUSY_LSU:
  - Required: `lsu_valid_o`=0; no DRAIN; pending ACC granted.
- Exception routing:
  - Stimulus: MMU returns page-fault exception for ACC.
  - Required: `acc_exception_o` equals input; LSU outputs unchanged.
- Wait counter:
  - Stimulus: ACC waits 10 cycles behind an LSU walk.
  - Required: `acc_wait_cnt_o`=10; it saturates at 0xFFFF under a forced long stall.
